// File: rtl/gnn_frame_loader.sv
// Serial-to-parallel frame loader for the 4-node GNN compute top.
// Double-buffers a 40-word stream and sequences the in_ready start level with a watchdog.
module gnn_frame_loader #(
    parameter int DW       = 5,
    parameter int N_X      = 16,
    parameter int N_W      = 24,
    parameter int MIN_HOLD = 3,
    parameter int TIMEOUT  = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    input  logic [DW-1:0]     s_data,
    output logic              s_ready,
    input  logic [7:0]        out_ready_vec,
    output logic [N_X*DW-1:0] x_flat,
    output logic [N_W*DW-1:0] w_flat,
    output logic              in_ready,
    output logic              busy,
    output logic [7:0]        frame_cnt,
    output logic              timeout_err
);
    localparam int N_T = N_X + N_W;
    localparam int CW  = $clog2(N_T);
    localparam int AW  = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST_WORD = CW'(N_T - 1);
    localparam logic [AW-1:0] HOLD_C    = AW'(MIN_HOLD);
    localparam logic [AW-1:0] TMO_C     = AW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ARMED, GAP} state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [CW-1:0]       r_wr_cnt;
    logic                r_shadow_full;
    logic [AW-1:0]       r_arm_cnt;
    logic [N_T*DW-1:0]   w_shadow;
    logic                w_accept;
    logic                w_commit;
    logic                w_done;
    logic                w_timeout;

    assign s_ready  = ~r_shadow_full;
    assign w_accept = s_valid & ~r_shadow_full;

    // One register per shadow slot; word index == slot index (features first, then weights).
    for (genvar gi = 0; gi < N_T; gi++) begin : g_slot
        logic [DW-1:0] r_word;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_word <= '0;
            end else if (w_accept && (r_wr_cnt == CW'(gi))) begin
                r_word <= s_data;
            end
        end
        assign w_shadow[gi*DW +: DW] = r_word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_cnt      <= '0;
            r_shadow_full <= 1'b0;
        end else if (w_accept) begin
            if (r_wr_cnt == LAST_WORD) begin
                r_wr_cnt      <= '0;
                r_shadow_full <= 1'b1;
            end else begin
                r_wr_cnt <= r_wr_cnt + CW'(1);
            end
        end else if (w_commit) begin
            r_shadow_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Completion outranks the watchdog when both fire on the same cycle.
    always_comb begin
        w_state_next = r_state;
        w_commit     = 1'b0;
        w_done       = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_shadow_full) begin
                    w_commit     = 1'b1;
                    w_state_next = ARMED;
                end
            end
            ARMED: begin
                if ((r_arm_cnt >= HOLD_C) && (&out_ready_vec)) begin
                    w_done       = 1'b1;
                    w_state_next = GAP;
                end else if (r_arm_cnt == TMO_C) begin
                    w_timeout    = 1'b1;
                    w_state_next = GAP;
                end
            end
            GAP:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_arm_cnt   <= '0;
            x_flat      <= '0;
            w_flat      <= '0;
            frame_cnt   <= '0;
            timeout_err <= 1'b0;
            in_ready    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            in_ready <= (r_state == ARMED);
            busy     <= (r_state != IDLE);
            if (w_commit) begin
                x_flat    <= w_shadow[N_X*DW-1:0];
                w_flat    <= w_shadow[N_T*DW-1:N_X*DW];
                r_arm_cnt <= '0;
            end else if ((r_state == ARMED) && (r_arm_cnt != TMO_C)) begin
                r_arm_cnt <= r_arm_cnt + AW'(1);
            end
            if (w_done) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
            if (w_timeout) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gnn_frame_loader.sv
// Scoreboard bench for gnn_frame_loader: frames are queued on load and checked when armed.
module tb_gnn_frame_loader;
    localparam int DW = 5, N_X = 16, N_W = 24, N_T = 40, MIN_HOLD = 3, TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              s_valid = 1'b0;
    logic [DW-1:0]     s_data = '0;
    logic              s_ready;
    logic [7:0]        out_ready_vec = 8'h00;
    logic [N_X*DW-1:0] x_flat;
    logic [N_W*DW-1:0] w_flat;
    logic              in_ready;
    logic              busy;
    logic [7:0]        frame_cnt;
    logic              timeout_err;

    gnn_frame_loader #(.DW(DW), .N_X(N_X), .N_W(N_W), .MIN_HOLD(MIN_HOLD), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .out_ready_vec(out_ready_vec), .x_flat(x_flat), .w_flat(w_flat), .in_ready(in_ready),
        .busy(busy), .frame_cnt(frame_cnt), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // d: out_ready_vec reads all-ones from arm cycle d onward (d > TIMEOUT: never).
    typedef struct {
        logic [N_X*DW-1:0] x;
        logic [N_W*DW-1:0] w;
        int                d;
        int                acc_cyc;
    } frame_t;

    frame_t sb_q[$];
    int     n_checks = 0;
    int     n_pass = 0;
    int     cyc = 0;
    int     last_acc_cyc = 0;
    int     last_rise_cyc = 0;

    frame_t     cur;
    int         h = 0;
    int         low_run = 0;
    int         k_exit = 0;
    bit         prev_ir = 1'b0;
    bit         have_cur = 1'b0;
    bit         gap2 = 1'b0;
    logic [7:0] exp_fc = 8'd0;
    logic       exp_terr = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s: event not seen as required (cycle %0d)", name, cyc);
    endtask

    // Monitor: pops a frame on each in_ready rise, checks hold length and counters on the fall.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_ir = 1'b0; have_cur = 1'b0; gap2 = 1'b0; h = 0; low_run = 0;
                exp_fc = 8'd0; exp_terr = 1'b0; out_ready_vec = 8'h00;
            end else begin
                if (in_ready && !prev_ir) begin
                    if (sb_q.size() == 0) begin
                        fail_now("unexpected_frame");
                        have_cur = 1'b0;
                    end else begin
                        cur = sb_q.pop_front();
                        have_cur = 1'b1;
                    end
                    if (gap2) check("gap_len", low_run, 2);
                    h = 0;
                    last_rise_cyc = cyc;
                end
                if (in_ready) begin
                    h++;
                    if (have_cur) begin
                        check("x_flat", x_flat, cur.x);
                        check("w_flat", w_flat, cur.w);
                    end
                    check("busy_armed", busy, 1);
                end else if (prev_ir) begin
                    if (have_cur) begin
                        k_exit = (cur.d > TIMEOUT) ? TIMEOUT : ((cur.d < MIN_HOLD) ? MIN_HOLD : cur.d);
                        check("armed_len", h, k_exit + 1);
                        if (cur.d <= TIMEOUT) exp_fc = exp_fc + 8'd1;
                        else exp_terr = 1'b1;
                    end
                    check("frame_cnt", frame_cnt, exp_fc);
                    check("timeout_err", timeout_err, exp_terr);
                    gap2 = (sb_q.size() > 0) && (sb_q[0].acc_cyc <= cyc);
                    low_run = 0;
                end
                if (!in_ready) low_run++;
                if (in_ready && have_cur) out_ready_vec = (h >= cur.d) ? 8'hFF : 8'h7F;
                else out_ready_vec = (sb_q.size() > 0 && sb_q[0].d == 0) ? 8'hFF : 8'h7F;
                prev_ir = in_ready;
            end
        end
    end

    task automatic send_frame(input logic [DW-1:0] wd [N_T], input int d, input int gap_pct, input int stop_at);
        frame_t f;
        int i = 0;
        int guard = 0;
        for (int j = 0; j < N_X; j++) f.x[j*DW +: DW] = wd[j];
        for (int j = 0; j < N_W; j++) f.w[j*DW +: DW] = wd[N_X+j];
        f.d = d;
        f.acc_cyc = 0;
        while (i < stop_at && guard < 4000) begin
            @(negedge clk);
            guard++;
            if ($urandom_range(99) < gap_pct) begin
                s_valid = 1'b0;
                s_data  = DW'($urandom);
            end else begin
                s_valid = 1'b1;
                s_data  = wd[i];
                if (s_ready) begin
                    if (i == N_T - 1) begin
                        f.acc_cyc = cyc + 1;
                        last_acc_cyc = f.acc_cyc;
                        sb_q.push_back(f);
                    end
                    i++;
                end
            end
        end
        if (i < stop_at) fail_now("load_timeout");
        if (stop_at == N_T) begin
            @(negedge clk);
            s_valid = 1'b0;
            s_data  = DW'($urandom);
            check("s_ready_after_full", s_ready, 0);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        s_valid = 1'b0;
        #1;
        check("rst_s_ready", s_ready, 1);
        check("rst_x_flat", x_flat, 0);
        check("rst_w_flat", w_flat, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_timeout_err", timeout_err, 0);
        @(negedge clk);
        sb_q.delete();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(sb_q.size() == 0 && !in_ready && !busy) && n < budget);
        if (n >= budget) fail_now("idle_timeout");
        @(negedge clk);
    endtask

    task automatic wait_ir(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < budget);
        if (!in_ready) fail_now("in_ready_timeout");
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "time limit");
    end

    initial begin
        logic [DW-1:0]     wd [N_T];
        logic [N_X*DW-1:0] all_m3;
        all_m3 = {N_X{5'h1D}};

        do_reset();

        // Counting pattern, continuous valid, flags high from the first armed cycle.
        for (int i = 0; i < N_T; i++) wd[i] = DW'(i % 16);
        send_frame(wd, 0, 0, N_T);
        wait_idle(300);
        check("t1_rise_latency", last_rise_cyc - last_acc_cyc, 2);
        check("t1_x_slot5", x_flat[5*DW +: DW], 5);
        check("t1_w_slot0", w_flat[0 +: DW], 0);
        check("t1_w_slot23", w_flat[23*DW +: DW], 7);
        check("t1_frame_cnt", frame_cnt, 1);

        // Flags never complete: watchdog path.
        for (int i = 0; i < N_T; i++) wd[i] = DW'($urandom);
        send_frame(wd, TIMEOUT + 1, 0, N_T);
        wait_idle(300);
        check("t3_timeout_err", timeout_err, 1);
        check("t3_in_ready", in_ready, 0);
        check("t3_frame_cnt", frame_cnt, 1);

        // Frame A (all 2) finishing exactly at the watchdog limit, frame B (all -3) back to back.
        for (int i = 0; i < N_T; i++) wd[i] = DW'(2);
        send_frame(wd, TIMEOUT, 0, N_T);
        for (int i = 0; i < N_T; i++) wd[i] = 5'h1D;
        send_frame(wd, 0, 0, N_T);
        wait_idle(300);
        check("t4_x_all_m3", x_flat, all_m3);
        check("t4_frame_cnt", frame_cnt, 3);

        // Random data, random completion points, 50% valid gaps.
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < N_T; i++) wd[i] = DW'($urandom);
            send_frame(wd, $urandom_range(0, TIMEOUT + 2), 50, N_T);
        end
        wait_idle(600);

        // Reset in the middle of a load, then a clean frame.
        for (int i = 0; i < N_T; i++) wd[i] = DW'($urandom);
        send_frame(wd, 0, 0, 20);
        do_reset();
        for (int i = 0; i < N_T; i++) wd[i] = DW'($urandom);
        send_frame(wd, 2, 0, N_T);
        wait_idle(300);
        check("t6a_frame_cnt", frame_cnt, 1);

        // Reset while armed, then a clean frame.
        for (int i = 0; i < N_T; i++) wd[i] = DW'($urandom);
        send_frame(wd, TIMEOUT + 1, 0, N_T);
        wait_ir(50);
        repeat (3) @(negedge clk);
        do_reset();
        for (int i = 0; i < N_T; i++) wd[i] = DW'($urandom);
        send_frame(wd, 5, 25, N_T);
        wait_idle(400);
        check("t6b_frame_cnt", frame_cnt, 1);
        check("t6b_timeout_err", timeout_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
